// File: rtl/stack_pkg.sv
// Shared opcode constants, FSM state type and per-opcode decode helpers for stack_seq.
`default_nettype none

package stack_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LIT  = 4'h1;
  localparam logic [3:0] OP_DROP = 4'h2;
  localparam logic [3:0] OP_DUP  = 4'h3;
  localparam logic [3:0] OP_SWAP = 4'h4;
  localparam logic [3:0] OP_OVER = 4'h5;
  localparam logic [3:0] OP_ADD  = 4'h6;
  localparam logic [3:0] OP_SUB  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOT  = 4'hB;
  localparam logic [3:0] OP_SHL  = 4'hC;
  localparam logic [3:0] OP_MUL  = 4'hD;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_t;

  typedef struct packed {
    logic push;
    logic pop;
    logic w_tos;
    logic w_next;
  } strobe_t;

  function automatic logic [1:0] op_min_depth(input logic [3:0] op);
    logic [1:0] r;
    r = 2'd0;
    case (op)
      OP_DROP, OP_DUP, OP_NOT, OP_SHL:                 r = 2'd1;
      OP_SWAP, OP_OVER, OP_ADD, OP_SUB, OP_AND,
      OP_OR, OP_XOR, OP_MUL:                           r = 2'd2;
      default:                                         r = 2'd0;
    endcase
    return r;
  endfunction

  function automatic logic op_grows(input logic [3:0] op);
    return (op == OP_LIT) || (op == OP_DUP) || (op == OP_OVER);
  endfunction

  function automatic logic op_shrinks(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_DROP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL: r = 1'b1;
      default:                                                r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic strobe_t op_strobes(input logic [3:0] op);
    strobe_t s;
    s = '0;
    case (op)
      OP_LIT, OP_OVER:                   begin s.push = 1'b1; s.w_tos = 1'b1; end
      OP_DROP:                           s.pop = 1'b1;
      OP_DUP:                            s.push = 1'b1;
      OP_SWAP:                           begin s.w_tos = 1'b1; s.w_next = 1'b1; end
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_MUL:                    begin s.pop = 1'b1; s.w_tos = 1'b1; end
      OP_NOT, OP_SHL:                    s.w_tos = 1'b1;
      default:                           s = '0;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stack_mul.sv
// Sequential shift-add multiplier: WIDTH iterations after start, low-half product.
`default_nettype none

module stack_mul #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_q + (b_q[0] ? a_q : '0);
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == LAST) busy_q <= 1'b0;
    end
  end

  // done marks the final iteration; the full product lands in acc on that edge
  assign done_o   = busy_q && (cnt_q == LAST);
  assign result_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/stack_seq.sv
// Instruction sequencer driving the control side of a two-entry-visible hardware stack.
`default_nettype none

module stack_seq
  import stack_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic [3:0]                   opcode,
  input  logic [WIDTH-1:0]             imm,
  input  logic [WIDTH-1:0]             top_out,
  input  logic [WIDTH-1:0]             next_out,
  output logic [WIDTH-1:0]             top_in,
  output logic [WIDTH-1:0]             next_in,
  output logic                         push,
  output logic                         pop,
  output logic                         w_tos,
  output logic                         w_next,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         ovf,
  output logic                         unf
);

  localparam int DW = $clog2(DEPTH + 1);

  state_t           state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] imm_q;
  logic             sup_q;
  logic [DW-1:0]    depth_q;
  logic             ovf_q, unf_q;
  strobe_t          strb_q;

  logic             w_hs, w_unf, w_ovf, w_sup, w_mul_start, w_mul_done;
  logic [WIDTH-1:0] w_mul_res;

  assign instr_ready = rst && (state_q == S_IDLE);
  assign w_hs        = instr_valid && instr_ready;
  assign w_unf       = depth_q < DW'(op_min_depth(opcode));
  assign w_ovf       = !w_unf && op_grows(opcode) && (depth_q == DW'(DEPTH));
  assign w_sup       = w_unf || w_ovf;
  assign w_mul_start = w_hs && (opcode == OP_MUL) && !w_sup;

  stack_mul #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (w_mul_start),
    .a_i      (next_out),
    .b_i      (top_out),
    .done_o   (w_mul_done),
    .result_o (w_mul_res)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      imm_q   <= '0;
      sup_q   <= 1'b0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      strb_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_hs) begin
            op_q  <= opcode;
            imm_q <= imm;
            sup_q <= w_sup;
            if (w_unf) unf_q <= 1'b1;
            if (w_ovf) ovf_q <= 1'b1;
            if (w_mul_start) begin
              state_q <= S_MUL;
            end else begin
              state_q <= S_EXEC;
              strb_q  <= w_sup ? '0 : op_strobes(opcode);
            end
          end
        end
        S_MUL: begin
          if (w_mul_done) begin
            state_q <= S_EXEC;
            strb_q  <= op_strobes(OP_MUL);
          end
        end
        S_EXEC: begin
          state_q <= S_IDLE;
          strb_q  <= '0;
          if (!sup_q) begin
            if (op_grows(op_q))        depth_q <= depth_q + DW'(1);
            else if (op_shrinks(op_q)) depth_q <= depth_q - DW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          strb_q  <= '0;
        end
      endcase
    end
  end

  // Write data follows the live stack outputs during EXEC, so results use the pre-op entries
  always_comb begin
    top_in  = '0;
    next_in = '0;
    if (state_q == S_EXEC && !sup_q) begin
      case (op_q)
        OP_LIT:  top_in = imm_q;
        OP_SWAP: begin top_in = next_out; next_in = top_out; end
        OP_OVER: top_in = next_out;
        OP_ADD:  top_in = next_out + top_out;
        OP_SUB:  top_in = next_out - top_out;
        OP_AND:  top_in = next_out & top_out;
        OP_OR:   top_in = next_out | top_out;
        OP_XOR:  top_in = next_out ^ top_out;
        OP_NOT:  top_in = ~top_out;
        OP_SHL:  top_in = top_out << 1;
        OP_MUL:  top_in = w_mul_res;
        default: top_in = '0;
      endcase
    end
  end

  assign push   = strb_q.push;
  assign pop    = strb_q.pop;
  assign w_tos  = strb_q.w_tos;
  assign w_next = strb_q.w_next;
  assign depth  = depth_q;
  assign ovf    = ovf_q;
  assign unf    = unf_q;

endmodule

`default_nettype wire
